otter_fetch_queue: RTL



---
 rtl/otter_pkg.sv | 34 +++
 rtl/fetch_fifo.sv | 76 +++++++
 rtl/otter_fetch_queue.sv | 127 ++++++++++++
 3 files changed

// File: rtl/otter_pkg.sv
// otter_pkg: shared types and constants for the OTTER front end.
//   opcode_t       - RV32I major opcodes (instruction bits [6:0])
//   NOP_INSTR      - addi x0, x0, 0; presented to decode when nothing is valid
//   fetch_state_t  - fetch control states
//   fetch_entry_t  - one buffered fetch: instruction word plus its PC tag
package otter_pkg;

    typedef enum logic [6:0] {
        OpLui    = 7'b0110111,
        OpAuipc  = 7'b0010111,
        OpJal    = 7'b1101111,
        OpJalr   = 7'b1100111,
        OpBranch = 7'b1100011,
        OpLoad   = 7'b0000011,
        OpStore  = 7'b0100011,
        OpImm    = 7'b0010011,
        OpReg    = 7'b0110011,
        OpSystem = 7'b1110011
    } opcode_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer of fetch_entry_t with wrap-around pointers.
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   clear_i        - drop all entries; overrides push_i and pop_i
//   push_i         - write push_data_i at the tail
//   pop_i          - remove the head (ignored when empty)
//   head_o         - current head entry (meaningful only when count_o != 0)
//   count_o        - occupancy, 0..DEPTH
module fetch_fifo
    import otter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_push = push_i & ~clear_i;
        do_pop  = pop_i & ~clear_i & (count_q != '0);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (do_push) mem_q[wptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

    // The upstream credit check must never let a push hit a full buffer.
    a_no_push_when_full : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (push_i && !clear_i) |-> (count_q != CW'(DEPTH))
    );

endmodule

// File: rtl/otter_fetch_queue.sv
// otter_fetch_queue: OTTER instruction-fetch front end feeding decode.
//   CLK, RST             - clock, asynchronous active-low reset
//   IMEM_RDEN/IMEM_ADDR  - word read request to instruction memory
//   IMEM_DOUT            - read data, returned one cycle after IMEM_RDEN
//   REDIRECT/REDIRECT_PC - execute-stage PC redirect; flushes all stale work
//   HALT                 - stop issuing new fetches; buffered entries still drain
//   DE_READY             - decode takes the head entry this cycle
//   IF_VALID/IF_IR/IF_PC/IF_PC_INC - head entry (NOP/zero when empty)
//   FQ_COUNT             - number of buffered entries
module otter_fetch_queue
    import otter_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int unsigned CW        = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    output logic          IMEM_RDEN,
    output logic [13:0]   IMEM_ADDR,
    input  logic [31:0]   IMEM_DOUT,
    input  logic          REDIRECT,
    input  logic [31:0]   REDIRECT_PC,
    input  logic          HALT,
    input  logic          DE_READY,
    output logic          IF_VALID,
    output logic [31:0]   IF_IR,
    output logic [31:0]   IF_PC,
    output logic [31:0]   IF_PC_INC,
    output logic [CW-1:0] FQ_COUNT
);

    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;

    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_head;
    fetch_entry_t  push_entry;
    logic          push;
    logic          pop;
    logic          credit_ok;
    logic [CW:0]   occupancy;
    logic          unused_redirect_lsb;

    assign unused_redirect_lsb = ^REDIRECT_PC[1:0];

    // Reserve a slot for the word already in flight so a response always
    // has room; the check uses the pre-pop count.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, rsp_valid_q};
    assign credit_ok = occupancy < (CW + 1)'(DEPTH);

    assign IMEM_RDEN = (state_q == RUN) & ~REDIRECT & credit_ok;
    assign IMEM_ADDR = fetch_pc_q[15:2];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (HALT) state_d = HALTED;
            HALTED:  if (!HALT) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        rsp_valid_d = 1'b0;
        rsp_pc_d    = rsp_pc_q;
        if (REDIRECT) begin
            // Drops the in-flight word along with the buffered entries.
            fetch_pc_d = {REDIRECT_PC[31:2], 2'b00};
        end else if (IMEM_RDEN) begin
            fetch_pc_d  = fetch_pc_q + 32'd4;
            rsp_valid_d = 1'b1;
            rsp_pc_d    = fetch_pc_q;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= BOOT;
            fetch_pc_q  <= RESET_VEC;
            rsp_valid_q <= 1'b0;
            rsp_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_pc_q    <= rsp_pc_d;
        end
    end

    assign push       = rsp_valid_q & ~REDIRECT;
    assign pop        = IF_VALID & DE_READY & ~REDIRECT;
    assign push_entry = '{ir: IMEM_DOUT, pc: rsp_pc_q};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk_i       (CLK),
        .rst_ni      (RST),
        .clear_i     (REDIRECT),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    always_comb begin
        IF_VALID  = fifo_count != '0;
        IF_IR     = NOP_INSTR;
        IF_PC     = '0;
        IF_PC_INC = '0;
        if (IF_VALID) begin
            IF_IR     = fifo_head.ir;
            IF_PC     = fifo_head.pc;
            IF_PC_INC = fifo_head.pc + 32'd4;
        end
    end

    assign FQ_COUNT = fifo_count;

endmodule
